data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder for the single-cycle/multi-cycle datapath. It sits on the far side of the `mem_read`/`mem_write` strobes issued by the control decoder. It services `ld` (doubleword read) and `sd` (doubleword write) requests against an internal doubleword array. Each access takes a programmable number of wait states, and completion is signalled with a one-cycle `mem_ready` pulse.

## Interface
- `ADDR_BITS`, default 5: log2 of the number of 64-bit words stored. The array holds 32 words by default.
- `WAIT_CYCLES`, default 2: wait states inserted between request acceptance and completion. Legal range is 0–15.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `mem_read`  input  1  read request (ld); held by requester until `mem_ready`.
- `mem_write`  input  1  write request (sd); held by requester until `mem_ready`.
- `addr`  input  64  byte address from the ALU result.
- `write_data`  input  64  store data; sampled with the request.
- `read_data`  output  64  load data; valid while `mem_ready`=1 for a read.
- `mem_ready`  output  1  one-cycle completion pulse.
- `mem_err`  output  1  qualifies `mem_ready`; 1 means the request was rejected.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - BUSY: counting wait states.
  - DONE: completion pulse.
- IDLE:
  - A rising edge with `mem_read` or `mem_write` high latches `addr`, `write_data` and the request type, and clears the wait counter.
  - The next state is BUSY, or DONE directly if `WAIT_CYCLES`=0.
- BUSY:
  - The counter increments each edge.
  - When counter = `WAIT_CYCLES`-1 the next state is DONE.
- DONE:
  - `mem_ready`=1 for exactly this one cycle.
  - The next state is IDLE unconditionally.
- Request inputs are ignored outside IDLE. Changes during BUSY/DONE do not affect the latched request.
- A request still asserted when the FSM is back in IDLE is a new request. The requester must drop its strobe in the DONE cycle.
- Word index = latched `addr[ADDR_BITS+2:3]`. Upper address bits are ignored, so the address wraps modulo 8·2^ADDR_BITS bytes.
- Error cases: misaligned (`addr[2:0]`≠0) or both strobes high at acceptance.
  - DONE is still reached with normal latency, with `mem_err`=1.
  - No write occurs.
  - `read_data`=0.
- Write: the array word is updated on the edge that enters DONE. `read_data`=0 in DONE for writes.
- Read: `read_data` is registered from the array on the edge entering DONE and held only during DONE. It is 0 in all other cycles.
- Array contents are not reset. Uninitialised words read as X in simulation.

## Timing
- Reset values:
  - FSM = IDLE, counter = 0.
  - `mem_ready`=0, `mem_err`=0, `read_data`=0.
  - Latched request is cleared.
- Latency: `mem_ready` rises WAIT_CYCLES+1 edges after the accepting edge (E0).
  - With `WAIT_CYCLES`=2: E0→BUSY(cnt 0), E1→BUSY(cnt 1), E2→DONE. `mem_ready` is high between E2 and E3.
  - With `WAIT_CYCLES`=0, `mem_ready` is high in the cycle after E0.
- Throughput: one access per WAIT_CYCLES+2 cycles, counting the DONE cycle and the IDLE re-accept cycle.
- `rst` asserted mid-access (BUSY or DONE):
  - Outputs clear immediately, with no clock needed.
  - The pending write is abandoned and its array word is unchanged.
  - After deassertion the FSM accepts a request on the first edge.
- `mem_err` is 0 whenever `mem_ready`=0.

## Test plan
- Reset then write: `rst` pulse, then `sd` with addr=0x10 and write_data=0xDEADBEEF_01234567. Required: `mem_ready` at E0+3 with `mem_err`=0, and `read_data`=0.
- Read-back: `ld` with addr=0x10 after the previous write. Required: after 3 edges `mem_ready`=1, `read_data`=0xDEADBEEF_01234567, and `mem_ready` lasts exactly 1 cycle.
- Wrap-around: `sd` with addr=0x100 and data=0xA5, then `ld` with addr=0x0. Required: read returns 0xA5 (32-word array).
- Errors:
  - `ld` with addr=0x13 gives `mem_ready`=1, `mem_err`=1, `read_data`=0.
  - `mem_read`=`mem_write`=1 with addr=0x18 and data=0x77 gives `mem_err`=1, and a later `ld` of 0x18 does not return 0x77.
- Reset mid-write: `sd` with addr=0x20 and data=0x55, with `rst` asserted asynchronously during BUSY. Required: `mem_ready`/`read_data` go to 0 before the next edge, and a subsequent `ld` of 0x20 does not return 0x55.
- Zero-wait build (`WAIT_CYCLES`=0) with back-to-back `ld` held continuously. Required: `mem_ready` pulses every 2nd cycle and is never high two cycles in a row.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle doubleword data memory: services ld/sd requests after WAIT_CYCLES wait states
// and signals completion with a one-cycle mem_ready pulse, qualified by mem_err.
module data_mem_responder #(
   parameter int unsigned ADDR_BITS   = 5,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [63:0] addr,
   input  logic [63:0] write_data,
   output logic [63:0] read_data,
   output logic        mem_ready,
   output logic        mem_err
);

   localparam int unsigned Words   = 1 << ADDR_BITS;
   localparam logic [3:0]  LastCnt = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] idx_q;
   logic [63:0]          wdata_q;
   logic                 write_q, err_q;
   logic [63:0]          rdata_q, rdata_d;
   logic [63:0]          mem [Words];

   logic                 accept, enter_done;
   logic [ADDR_BITS-1:0] cur_idx;
   logic [63:0]          cur_wdata;
   logic                 cur_write, cur_err;

   // Upper address bits only select aliases of the same word.
   logic unused_addr;
   assign unused_addr = ^addr[63:ADDR_BITS+3];

   always_comb begin
      accept = (state_q == StIdle) && (mem_read || mem_write);
      // With zero wait states DONE is entered on the accepting edge, so use the live request.
      cur_idx   = accept ? addr[ADDR_BITS+2:3] : idx_q;
      cur_wdata = accept ? write_data : wdata_q;
      cur_write = accept ? mem_write : write_q;
      cur_err   = accept ? ((addr[2:0] != 3'b000) || (mem_read && mem_write)) : err_q;

      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               cnt_d   = 4'd0;
               state_d = (WAIT_CYCLES == 0) ? StDone : StBusy;
            end
         end
         StBusy: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LastCnt) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      enter_done = (state_d == StDone) && (state_q != StDone);
      rdata_d    = (enter_done && !cur_write && !cur_err) ? mem[cur_idx] : 64'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 64'd0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 64'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         if (accept) begin
            idx_q   <= cur_idx;
            wdata_q <= cur_wdata;
            write_q <= cur_write;
            err_q   <= cur_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && enter_done && cur_write && !cur_err) mem[cur_idx] <= cur_wdata;
   end

   assign mem_ready = (state_q == StDone);
   assign mem_err   = mem_ready & err_q;
   assign read_data = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded random/directed bench for data_mem_responder (WAIT_CYCLES=2 and 0 builds).
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [63:0] addr = 64'd0, write_data = 64'd0;
   logic [63:0] read_data;
   logic        mem_ready, mem_err;

   logic        rd0 = 1'b0, wr0 = 1'b0;
   logic [63:0] addr0 = 64'd0, wd0 = 64'd0;
   logic [63:0] rdata0;
   logic        ready0, err0;

   int vectors = 0;
   int miscompares = 0;

   logic [63:0] model [32];
   logic [63:0] exp_rd_q [$];
   logic        exp_err_q [$];

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_BITS(5), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
      .write_data(write_data), .read_data(read_data), .mem_ready(mem_ready), .mem_err(mem_err)
   );

   data_mem_responder #(.ADDR_BITS(5), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .addr(addr0),
      .write_data(wd0), .read_data(rdata0), .mem_ready(ready0), .mem_err(err0)
   );

   // Monitor: pops an expectation whenever the DUT completes; otherwise outputs must be quiet.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_ready) begin
            vectors++;
            if (exp_rd_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_ready: got mem_ready=1, required no pending request");
            end else begin
               logic [63:0] er;
               logic        ee;
               er = exp_rd_q.pop_front();
               ee = exp_err_q.pop_front();
               if (read_data !== er || mem_err !== ee) begin
                  miscompares++;
                  $display("FAIL response: got data=%h err=%b, required data=%h err=%b",
                           read_data, mem_err, er, ee);
               end
            end
         end else begin
            vectors++;
            if (mem_err !== 1'b0 || read_data !== 64'd0) begin
               miscompares++;
               $display("FAIL idle_outputs: got err=%b data=%h, required 0 and 0",
                        mem_err, read_data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   // Issue one request from a negedge, expect completion 3 edges later, then a 1-cycle pulse.
   task automatic do_req(input logic rd, input logic wr, input logic [63:0] a,
                         input logic [63:0] d);
      logic       err;
      logic [4:0] idx;
      int         n;
      err = (a[2:0] != 3'b000) || (rd && wr);
      idx = a[7:3];
      exp_rd_q.push_back((rd && !wr && !err) ? model[idx] : 64'd0);
      exp_err_q.push_back(err);
      if (wr && !rd && !err) model[idx] = d;
      mem_read = rd; mem_write = wr; addr = a; write_data = d;
      n = 0;
      do begin
         @(posedge clk); @(negedge clk);
         n++;
      end while (!mem_ready && n < 20);
      mem_read = 1'b0; mem_write = 1'b0;
      check("latency", 64'(n), 64'd3);
      @(posedge clk); @(negedge clk);
      check("pulse_width", {63'd0, mem_ready}, 64'd0);
   endtask

   initial begin
      #1;
      check("reset_ready", {63'd0, mem_ready}, 64'd0);
      check("reset_err", {63'd0, mem_err}, 64'd0);
      check("reset_data", read_data, 64'd0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 32; i++) do_req(1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom} | 64'h1_0000_0000);

      // Directed scenarios
      do_req(1'b0, 1'b1, 64'h10, 64'hDEADBEEF_01234567);
      do_req(1'b1, 1'b0, 64'h10, 64'd0);
      do_req(1'b0, 1'b1, 64'h100, 64'hA5);
      do_req(1'b1, 1'b0, 64'h0, 64'd0);
      do_req(1'b1, 1'b0, 64'h13, 64'd0);
      do_req(1'b1, 1'b1, 64'h18, 64'h77);
      do_req(1'b1, 1'b0, 64'h18, 64'd0);

      // Reset during BUSY of a write: outputs clear at once, word 4 keeps its old value
      mem_write = 1'b1; addr = 64'h20; write_data = 64'h55;
      @(posedge clk); #2;
      rst = 1'b1; #1;
      check("rst_busy_ready", {63'd0, mem_ready}, 64'd0);
      check("rst_busy_data", read_data, 64'd0);
      mem_write = 1'b0; #1 rst = 1'b0;
      @(negedge clk);
      do_req(1'b1, 1'b0, 64'h20, 64'd0);

      // Reset during DONE of a read: outputs drop without a clock edge
      exp_rd_q.push_back(model[2]); exp_err_q.push_back(1'b0);
      mem_read = 1'b1; addr = 64'h10;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b1; #1;
      check("rst_done_ready", {63'd0, mem_ready}, 64'd0);
      check("rst_done_data", read_data, 64'd0);
      mem_read = 1'b0; #1 rst = 1'b0;
      @(negedge clk);

      // Randomized traffic against the word-array model
      for (int i = 0; i < 60; i++) begin
         logic [63:0] a;
         int          op;
         a  = {$urandom, $urandom};
         op = int'($urandom_range(0, 9));
         if (op < 4)      do_req(1'b1, 1'b0, {a[63:3], 3'b000}, 64'd0);
         else if (op < 8) do_req(1'b0, 1'b1, {a[63:3], 3'b000}, {$urandom, $urandom});
         else if (op < 9) do_req(1'b1, 1'b0, a | 64'd1, 64'd0);
         else             do_req(1'b1, 1'b1, a, {$urandom, $urandom});
      end
      check("queue_drained", 64'(exp_rd_q.size()), 64'd0);

      // Zero-wait build: write then hold ld continuously
      wr0 = 1'b1; addr0 = 64'h8; wd0 = 64'h0123_4567_89AB_CDEF;
      @(posedge clk); @(negedge clk);
      check("zw_write_ready", {63'd0, ready0}, 64'd1);
      check("zw_write_err", {63'd0, err0}, 64'd0);
      wr0 = 1'b0;
      @(posedge clk); @(negedge clk);
      check("zw_write_pulse", {63'd0, ready0}, 64'd0);
      rd0 = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); @(negedge clk);
         check("zw_ready_pattern", {63'd0, ready0}, (k % 2 == 0) ? 64'd1 : 64'd0);
         if (k % 2 == 0) check("zw_read_data", rdata0, 64'h0123_4567_89AB_CDEF);
      end
      rd0 = 1'b0;
      @(posedge clk); @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
